// File: rtl/irda_rx_decoder_pkg.sv
// Shared types and default timing for the IrDA receive decoder.
// Defaults assume a 50 MHz clock and 9600 baud.
package irda_rx_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_HOLD  = 3'b010,
    ST_STUCK = 3'b100
  } state_t;

  localparam int DEF_CLKS_PER_BIT   = 5208;
  localparam int DEF_MIN_PULSE_CLKS = 16;
  localparam int DEF_MAX_PULSE_CLKS = 2604;

  // Pulse filter to FSM handoff
  typedef struct packed {
    logic ir_s;
    logic pulse_ok;
    logic stuck;
  } filt_t;

endpackage

// File: rtl/irda_pulse_filter.sv
// Synchronizes the raw IR input and measures high-pulse width.
// pulse_ok fires once per pulse; stuck is a level while the count is saturated.
module irda_pulse_filter
  import irda_rx_decoder_pkg::*;
#(
  parameter int MIN_PULSE_CLKS = DEF_MIN_PULSE_CLKS,
  parameter int MAX_PULSE_CLKS = DEF_MAX_PULSE_CLKS,
  parameter int CNT_W          = $clog2(DEF_CLKS_PER_BIT + 1)
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  enable,
  input  logic  ir_in,
  output filt_t filt
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PULSE_CLKS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PULSE_CLKS);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] hi_cnt;
  logic             ir_s;

  // Synchronizer runs regardless of enable
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], ir_in};
  end

  assign ir_s = sync_q[1];

  always_ff @(posedge clock) begin
    if (reset || !enable || !ir_s) hi_cnt <= '0;
    else if (hi_cnt != MAX_C)      hi_cnt <= hi_cnt + CNT_W'(1);
  end

  // MIN < MAX, so the saturated count can never re-trigger pulse_ok
  assign filt.ir_s     = ir_s;
  assign filt.pulse_ok = (hi_cnt == MIN_C);
  assign filt.stuck    = (hi_cnt == MAX_C);

endmodule

// File: rtl/irda_rx_decoder.sv
// IrDA SIR receive decoder: stretches each accepted IR pulse into a full
// low bit period on rx_D, and flags inputs stuck high.
module irda_rx_decoder
  import irda_rx_decoder_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEF_CLKS_PER_BIT,
  parameter int MIN_PULSE_CLKS = DEF_MIN_PULSE_CLKS,
  parameter int MAX_PULSE_CLKS = DEF_MAX_PULSE_CLKS
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic ir_in,
  output logic rx_D,
  output logic busy,
  output logic pulse_err
);

  // Legal only for 1 <= MIN_PULSE_CLKS < MAX_PULSE_CLKS < CLKS_PER_BIT
  localparam int               CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_C = CNT_W'(CLKS_PER_BIT);

  filt_t            filt;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             rx_d_nxt, busy_nxt, err_nxt;

  irda_pulse_filter #(
    .MIN_PULSE_CLKS (MIN_PULSE_CLKS),
    .MAX_PULSE_CLKS (MAX_PULSE_CLKS),
    .CNT_W          (CNT_W)
  ) u_filt (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .ir_in  (ir_in),
    .filt   (filt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      rx_D      <= 1'b1;
      busy      <= 1'b0;
      pulse_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      rx_D      <= rx_d_nxt;
      busy      <= busy_nxt;
      pulse_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (!enable) begin
      state_nxt = ST_IDLE;
      hold_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (filt.stuck) begin
            state_nxt = ST_STUCK;
            hold_nxt  = '0;
          end else if (filt.pulse_ok) begin
            state_nxt = ST_HOLD;
            hold_nxt  = BIT_C;
          end
        end
        ST_HOLD: begin
          // A reload on the final hold cycle keeps rx_D low without a gap
          if (filt.stuck) begin
            state_nxt = ST_STUCK;
            hold_nxt  = '0;
          end else if (filt.pulse_ok) begin
            hold_nxt  = BIT_C;
          end else if (hold_cnt <= CNT_W'(1)) begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
          end else begin
            hold_nxt  = hold_cnt - CNT_W'(1);
          end
        end
        ST_STUCK: begin
          if (!filt.ir_s) state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they align with it
  always_comb begin
    rx_d_nxt = (state_nxt != ST_HOLD);
    busy_nxt = (state_nxt == ST_HOLD);
    err_nxt  = (state_nxt == ST_STUCK) && (state != ST_STUCK);
  end

endmodule

// File: tb/tb_irda_rx_decoder.sv
// Directed bench for irda_rx_decoder with short timing parameters.
module tb_irda_rx_decoder;

  localparam int CPB  = 32;
  localparam int MINP = 4;
  localparam int MAXP = 16;
  localparam int NMAX = 128;

  logic clock = 1'b0;
  logic reset, enable, ir_in;
  logic rx_D, busy, pulse_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-edge stimulus; index k is the value sampled at edge k
  logic stim [NMAX];
  logic en_v [NMAX];
  logic rst_v[NMAX];
  // Outputs observed after edge k
  logic rx_log  [NMAX];
  logic busy_log[NMAX];
  logic err_log [NMAX];

  always #5 clock = ~clock;

  irda_rx_decoder #(
    .CLKS_PER_BIT   (CPB),
    .MIN_PULSE_CLKS (MINP),
    .MAX_PULSE_CLKS (MAXP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .ir_in     (ir_in),
    .rx_D      (rx_D),
    .busy      (busy),
    .pulse_err (pulse_err)
  );

  task automatic clear_vec();
    for (int k = 0; k < NMAX; k++) begin
      stim[k]  = 1'b0;
      en_v[k]  = 1'b1;
      rst_v[k] = 1'b0;
    end
  endtask

  task automatic set_hi(input int a, input int b);
    for (int k = a; k <= b; k++) stim[k] = 1'b1;
  endtask

  task automatic idle(input int n);
    ir_in  = 1'b0;
    enable = 1'b1;
    reset  = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic run_seq(input int len);
    for (int k = 0; k < len; k++) begin
      ir_in  = stim[k];
      enable = en_v[k];
      reset  = rst_v[k];
      @(negedge clock);
      rx_log[k]   = rx_D;
      busy_log[k] = busy;
      err_log[k]  = pulse_err;
    end
    ir_in  = 1'b0;
    enable = 1'b1;
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; ir_in = 1'b1;
    repeat (3) @(negedge clock);
    n_chk++; if (rx_D !== 1'b1)               begin n_fail++; $display("FAIL reset rx_D: got %b want 1", rx_D); end
    n_chk++; if (busy !== 1'b0)               begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_chk++; if (pulse_err !== 1'b0)          begin n_fail++; $display("FAIL reset pulse_err: got %b want 0", pulse_err); end
    n_chk++; if (dut.u_filt.sync_q !== 2'b00) begin n_fail++; $display("FAIL reset sync: got %b want 00", dut.u_filt.sync_q); end
    n_chk++; if (dut.u_filt.hi_cnt !== '0)    begin n_fail++; $display("FAIL reset hi_cnt: got %0d want 0", dut.u_filt.hi_cnt); end
    n_chk++; if (dut.hold_cnt !== '0)         begin n_fail++; $display("FAIL reset hold_cnt: got %0d want 0", dut.hold_cnt); end
    n_chk++; if (dut.state !== 3'b001)        begin n_fail++; $display("FAIL reset state: got %b want 001", dut.state); end
    ir_in = 1'b0;
    @(negedge clock);
    idle(6);
  endtask

  task automatic test_single_pulse();
    logic exp_rx;
    clear_vec(); set_hi(0, 5); run_seq(45);
    for (int k = 0; k < 45; k++) begin
      exp_rx = !(k >= 6 && k <= 37);
      n_chk++; if (rx_log[k] !== exp_rx)    begin n_fail++; $display("FAIL single rx_D edge %0d: got %b want %b", k, rx_log[k], exp_rx); end
      n_chk++; if (busy_log[k] !== !exp_rx) begin n_fail++; $display("FAIL single busy edge %0d: got %b want %b", k, busy_log[k], !exp_rx); end
      n_chk++; if (err_log[k] !== 1'b0)     begin n_fail++; $display("FAIL single pulse_err edge %0d: got %b want 0", k, err_log[k]); end
    end
    idle(8);
  endtask

  task automatic test_glitch();
    clear_vec(); set_hi(0, 2); run_seq(20);
    for (int k = 0; k < 20; k++) begin
      n_chk++; if (rx_log[k] !== 1'b1)   begin n_fail++; $display("FAIL glitch rx_D edge %0d: got %b want 1", k, rx_log[k]); end
      n_chk++; if (busy_log[k] !== 1'b0) begin n_fail++; $display("FAIL glitch busy edge %0d: got %b want 0", k, busy_log[k]); end
      n_chk++; if (err_log[k] !== 1'b0)  begin n_fail++; $display("FAIL glitch pulse_err edge %0d: got %b want 0", k, err_log[k]); end
    end
    idle(8);
  endtask

  task automatic test_back_to_back();
    logic exp_rx;
    clear_vec(); set_hi(0, 5); set_hi(32, 37); run_seq(78);
    for (int k = 0; k < 78; k++) begin
      exp_rx = !(k >= 6 && k <= 69);
      n_chk++; if (rx_log[k] !== exp_rx)    begin n_fail++; $display("FAIL b2b rx_D edge %0d: got %b want %b", k, rx_log[k], exp_rx); end
      n_chk++; if (busy_log[k] !== !exp_rx) begin n_fail++; $display("FAIL b2b busy edge %0d: got %b want %b", k, busy_log[k], !exp_rx); end
    end
    idle(8);
  endtask

  task automatic test_stuck();
    logic exp_rx;
    clear_vec(); set_hi(0, 24); set_hi(40, 45); run_seq(85);
    for (int k = 0; k < 85; k++) begin
      exp_rx = !((k >= 6 && k <= 17) || (k >= 46 && k <= 77));
      n_chk++; if (rx_log[k] !== exp_rx)          begin n_fail++; $display("FAIL stuck rx_D edge %0d: got %b want %b", k, rx_log[k], exp_rx); end
      n_chk++; if (busy_log[k] !== !exp_rx)       begin n_fail++; $display("FAIL stuck busy edge %0d: got %b want %b", k, busy_log[k], !exp_rx); end
      n_chk++; if (err_log[k] !== (k == 18))      begin n_fail++; $display("FAIL stuck pulse_err edge %0d: got %b want %b", k, err_log[k], k == 18); end
    end
    idle(8);
  endtask

  task automatic test_reset_mid_hold();
    logic exp_rx;
    // Hold cycle 1 is edge 6, so hold cycle 10 is edge 15
    clear_vec(); set_hi(0, 5); rst_v[15] = 1'b1; run_seq(15);
    ir_in = 1'b0; reset = 1'b1;
    @(negedge clock);
    rx_log[15] = rx_D; busy_log[15] = busy; err_log[15] = pulse_err;
    n_chk++; if (dut.hold_cnt !== '0)      begin n_fail++; $display("FAIL rst_hold hold_cnt: got %0d want 0", dut.hold_cnt); end
    n_chk++; if (dut.u_filt.hi_cnt !== '0) begin n_fail++; $display("FAIL rst_hold hi_cnt: got %0d want 0", dut.u_filt.hi_cnt); end
    n_chk++; if (dut.state !== 3'b001)     begin n_fail++; $display("FAIL rst_hold state: got %b want 001", dut.state); end
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_rx = !(k >= 6 && k <= 14);
      n_chk++; if (rx_log[k] !== exp_rx)    begin n_fail++; $display("FAIL rst_hold rx_D edge %0d: got %b want %b", k, rx_log[k], exp_rx); end
      n_chk++; if (busy_log[k] !== !exp_rx) begin n_fail++; $display("FAIL rst_hold busy edge %0d: got %b want %b", k, busy_log[k], !exp_rx); end
      n_chk++; if (err_log[k] !== 1'b0)     begin n_fail++; $display("FAIL rst_hold pulse_err edge %0d: got %b want 0", k, err_log[k]); end
    end
    idle(8);
  endtask

  task automatic test_reset_mid_stuck();
    logic exp_rx;
    clear_vec(); set_hi(0, 21); rst_v[20] = 1'b1; run_seq(30);
    for (int k = 0; k < 30; k++) begin
      exp_rx = !(k >= 6 && k <= 17);
      n_chk++; if (rx_log[k] !== exp_rx)     begin n_fail++; $display("FAIL rst_stuck rx_D edge %0d: got %b want %b", k, rx_log[k], exp_rx); end
      n_chk++; if (err_log[k] !== (k == 18)) begin n_fail++; $display("FAIL rst_stuck pulse_err edge %0d: got %b want %b", k, err_log[k], k == 18); end
    end
    idle(8);
  endtask

  task automatic test_enable();
    logic exp_rx;
    clear_vec(); set_hi(0, 5);
    for (int k = 0; k < NMAX; k++) en_v[k] = 1'b0;
    run_seq(45);
    for (int k = 0; k < 45; k++) begin
      n_chk++; if (rx_log[k] !== 1'b1)   begin n_fail++; $display("FAIL en_off rx_D edge %0d: got %b want 1", k, rx_log[k]); end
      n_chk++; if (busy_log[k] !== 1'b0) begin n_fail++; $display("FAIL en_off busy edge %0d: got %b want 0", k, busy_log[k]); end
    end
    idle(8);
    clear_vec(); set_hi(0, 24);
    for (int k = 0; k < NMAX; k++) en_v[k] = 1'b0;
    run_seq(30);
    for (int k = 0; k < 30; k++) begin
      n_chk++; if (err_log[k] !== 1'b0) begin n_fail++; $display("FAIL en_off pulse_err edge %0d: got %b want 0", k, err_log[k]); end
    end
    idle(8);
    clear_vec(); set_hi(0, 5); run_seq(45);
    for (int k = 0; k < 45; k++) begin
      exp_rx = !(k >= 6 && k <= 37);
      n_chk++; if (rx_log[k] !== exp_rx)    begin n_fail++; $display("FAIL en_on rx_D edge %0d: got %b want %b", k, rx_log[k], exp_rx); end
      n_chk++; if (busy_log[k] !== !exp_rx) begin n_fail++; $display("FAIL en_on busy edge %0d: got %b want %b", k, busy_log[k], !exp_rx); end
    end
    idle(8);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; ir_in = 1'b0;
    @(negedge clock);
    test_reset();
    test_single_pulse();
    test_glitch();
    test_back_to_back();
    test_stuck();
    test_reset_mid_hold();
    test_reset_mid_stuck();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
